// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: occupancy encoding,
// the bubble fill value and the saturating counter helper.
package pipe_pkg;

  localparam int unsigned OCC_W          = 2;
  localparam int unsigned PIPE_CNT_MAX_W = 64;

  localparam logic [OCC_W-1:0] PIPE_OCC_EMPTY = OCC_W'(0);
  localparam logic [OCC_W-1:0] PIPE_OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] PIPE_OCC_FULL  = OCC_W'(2);

  // Replicated to the payload width, so a killed slot decodes as a NOP downstream.
  localparam logic PIPE_BUBBLE_BIT = 1'b0;

  // Increment, holding at all-ones of a counter that is `width` bits wide (width <= 64).
  function automatic logic [PIPE_CNT_MAX_W-1:0] pipe_sat_inc(
    input logic [PIPE_CNT_MAX_W-1:0] cnt,
    input int unsigned               width
  );
    logic [PIPE_CNT_MAX_W-1:0] all_ones;
    all_ones = (PIPE_CNT_MAX_W'(1) << width) - PIPE_CNT_MAX_W'(1);
    if (cnt == all_ones) begin
      return cnt;
    end
    return cnt + PIPE_CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with its valid bit. Reset and clear both empty it and
// zero the payload; drop only empties it, so the payload never toggles while unused.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      q     <= {DATA_W{PIPE_BUBBLE_BIT}};
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, optional skid entry,
// legacy stall/flush. Define PIPE_STAGE_PERF_EN to build the stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              main_valid;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic              main_load;
  logic              main_drop;
  logic              skid_valid;
  logic              take;
  logic              give;

  // Gated by rst so nothing is handed downstream in the reset cycle itself.
  assign dn_valid_o = main_valid & ~rst;
  assign dn_data_o  = dn_valid_o ? main_q : {DATA_W{PIPE_BUBBLE_BIT}};
  assign give       = dn_valid_o & dn_ready_i & ~stall_i;
  assign take       = up_valid_i & up_ready_o;
  assign occ_o      = OCC_W'(main_valid) + OCC_W'(skid_valid);

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if (SKID_EN != 0) begin : g_skid
    logic              skid_load;
    logic              skid_drop;
    logic [DATA_W-1:0] skid_q;

    // Ready comes straight from a flop: no combinational path from dn_ready_i.
    assign up_ready_o = ~skid_valid;

    // Main refills from skid first to keep FIFO order; skid catches the overflow beat.
    always_comb begin
      main_load = 1'b0;
      main_drop = 1'b0;
      skid_load = 1'b0;
      skid_drop = 1'b0;
      main_d    = up_data_i;
      if (!main_valid || give) begin
        if (skid_valid) begin
          main_load = 1'b1;
          main_d    = skid_q;
          skid_load = take;
          skid_drop = ~take;
        end else if (take) begin
          main_load = 1'b1;
        end else begin
          main_drop = 1'b1;
        end
      end else if (take) begin
        skid_load = 1'b1;
      end
    end

    pipe_slot #(.DATA_W(DATA_W)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clear (flush_i),
      .load  (skid_load),
      .drop  (skid_drop),
      .d     (up_data_i),
      .valid (skid_valid),
      .q     (skid_q)
    );
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    // Single entry: a beat leaving this cycle frees the slot for the incoming one.
    assign up_ready_o = ~main_valid | give;

    always_comb begin
      main_load = take;
      main_drop = give & ~take;
      main_d    = up_data_i;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Flush events count only when they actually kill a beat (held or arriving).
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (dn_valid_o && !give) begin
        stall_cnt_q <= CNT_W'(pipe_sat_inc(PIPE_CNT_MAX_W'(stall_cnt_q), CNT_W));
      end
      if (flush_i && ((occ_o != PIPE_OCC_EMPTY) || take)) begin
        flush_cnt_q <= CNT_W'(pipe_sat_inc(PIPE_CNT_MAX_W'(flush_cnt_q), CNT_W));
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance and a single-entry instance,
// each tracked by a queue model of the beats it holds.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic              a_up_valid, a_up_ready, a_dn_valid, a_dn_ready, a_stall, a_flush;
  logic [DATA_W-1:0] a_up_data, a_dn_data;
  logic [1:0]        a_occ;
  logic [CNT_W-1:0]  a_stall_cnt, a_flush_cnt;

  logic              b_up_valid, b_up_ready, b_dn_valid, b_dn_ready, b_stall, b_flush;
  logic [DATA_W-1:0] b_up_data, b_dn_data;
  logic [1:0]        b_occ;
  logic [CNT_W-1:0]  b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] aq[$];
  logic [DATA_W-1:0] bq[$];
  logic [CNT_W-1:0]  a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic              a_took, b_took;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .SKID_EN(1), .CNT_W(CNT_W)) u_dut_skid (
    .clk(clk), .rst(rst),
    .up_valid_i(a_up_valid), .up_ready_o(a_up_ready), .up_data_i(a_up_data),
    .dn_valid_o(a_dn_valid), .dn_ready_i(a_dn_ready), .dn_data_o(a_dn_data),
    .stall_i(a_stall), .flush_i(a_flush), .occ_o(a_occ),
    .stall_cnt_o(a_stall_cnt), .flush_cnt_o(a_flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .SKID_EN(0), .CNT_W(CNT_W)) u_dut_noskid (
    .clk(clk), .rst(rst),
    .up_valid_i(b_up_valid), .up_ready_o(b_up_ready), .up_data_i(b_up_data),
    .dn_valid_o(b_dn_valid), .dn_ready_i(b_dn_ready), .dn_data_o(b_dn_data),
    .stall_i(b_stall), .flush_i(b_flush), .occ_o(b_occ),
    .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare against the models on the falling edge, then advance them to the rising edge.
  task automatic step();
    logic a_rdy, a_give, a_take, b_rdy, b_give, b_take;
    logic [DATA_W-1:0] a_head, b_head, popped;
    @(negedge clk);
    a_head = (aq.size() != 0) ? aq[0] : '0;
    b_head = (bq.size() != 0) ? bq[0] : '0;
    a_rdy  = aq.size() < 2;
    a_give = !rst && aq.size() != 0 && a_dn_ready && !a_stall;
    a_take = a_up_valid && a_rdy;
    b_give = !rst && bq.size() != 0 && b_dn_ready && !b_stall;
    b_rdy  = (bq.size() == 0) || b_give;
    b_take = b_up_valid && b_rdy;

    if (rst) begin
      chk("a_valid_in_rst", 32'(a_dn_valid), 32'(0));
      chk("b_valid_in_rst", 32'(b_dn_valid), 32'(0));
      aq.delete();
      bq.delete();
      a_scnt = '0; a_fcnt = '0; b_scnt = '0; b_fcnt = '0;
    end else begin
      chk("a_up_ready",  32'(a_up_ready), 32'(a_rdy));
      chk("a_dn_valid",  32'(a_dn_valid), 32'(aq.size() != 0));
      chk("a_dn_data",   32'(a_dn_data),  32'(a_head));
      chk("a_occ",       32'(a_occ),      32'(aq.size()));
      chk("a_stall_cnt", 32'(a_stall_cnt), 32'(PERF ? a_scnt : CNT_W'(0)));
      chk("a_flush_cnt", 32'(a_flush_cnt), 32'(PERF ? a_fcnt : CNT_W'(0)));
      chk("b_up_ready",  32'(b_up_ready), 32'(b_rdy));
      chk("b_dn_valid",  32'(b_dn_valid), 32'(bq.size() != 0));
      chk("b_dn_data",   32'(b_dn_data),  32'(b_head));
      chk("b_occ",       32'(b_occ),      32'(bq.size()));
      chk("b_stall_cnt", 32'(b_stall_cnt), 32'(PERF ? b_scnt : CNT_W'(0)));
      chk("b_flush_cnt", 32'(b_flush_cnt), 32'(PERF ? b_fcnt : CNT_W'(0)));

      if (aq.size() != 0 && !a_give && a_scnt != '1) a_scnt++;
      if (a_flush) begin
        if ((aq.size() != 0 || a_take) && a_fcnt != '1) a_fcnt++;
        aq.delete();
      end else begin
        if (a_give) begin
          popped = aq.pop_front();
          chk("a_beat", 32'(a_dn_data), 32'(popped));
        end
        if (a_take) aq.push_back(a_up_data);
      end

      if (bq.size() != 0 && !b_give && b_scnt != '1) b_scnt++;
      if (b_flush) begin
        if ((bq.size() != 0 || b_take) && b_fcnt != '1) b_fcnt++;
        bq.delete();
      end else begin
        if (b_give) begin
          popped = bq.pop_front();
          chk("b_beat", 32'(b_dn_data), 32'(popped));
        end
        if (b_take) bq.push_back(b_up_data);
      end
    end
    a_took = a_take && !rst;
    b_took = b_take && !rst;
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the skid instance and hold it until accepted.
  task automatic send_a(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    a_up_valid = 1'b1;
    a_up_data  = d;
    do begin
      step();
      n++;
    end while (!a_took && n < 16);
    if (!a_took) begin
      checks++;
      errors++;
      $error("FAIL a_send_timeout observed=no_take expected=take data=0x%0h", d);
    end
    a_up_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_up_valid = 1'b0; a_up_data = '0; a_dn_ready = 1'b1; a_stall = 1'b0; a_flush = 1'b0;
    b_up_valid = 1'b0; b_up_data = '0; b_dn_ready = 1'b1; b_stall = 1'b0; b_flush = 1'b0;
    aq.delete(); bq.delete();
    a_scnt = '0; a_fcnt = '0; b_scnt = '0; b_fcnt = '0;
    a_took = 1'b0; b_took = 1'b0;
    #1;
    step();
    step();
    rst = 1'b0;

    // reset state, then streaming at full rate
    step();
    chk("rst_up_ready", 32'(a_up_ready), 32'(1));
    chk("rst_occ", 32'(a_occ), 32'(PIPE_OCC_EMPTY));
    for (int i = 1; i <= 4; i++) begin
      a_up_valid = 1'b1;
      a_up_data  = DATA_W'(i);
      step();
    end
    a_up_valid = 1'b0;
    step();
    step();

    // back-pressure fills the skid entry
    send_a(DATA_W'(10));
    a_dn_ready = 1'b0;
    send_a(DATA_W'(11));
    chk("bp_skid_full", 32'(a_occ), 32'(PIPE_OCC_FULL));
    chk("bp_ready_low", 32'(a_up_ready), 32'(0));
    a_up_valid = 1'b1;
    a_up_data  = DATA_W'(12);
    step();
    step();
    a_dn_ready = 1'b1;
    send_a(DATA_W'(12));
    repeat (3) step();

    // legacy stall holds the output
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_a(DATA_W'(16'h55));
    a_stall = 1'b1;
    repeat (3) step();
    chk("stall_hold", 32'(a_dn_data), 32'h55);
    chk("stall_cnt3", 32'(a_stall_cnt), 32'(PERF ? 3 : 0));
    a_stall = 1'b0;
    step();
    step();

    // flush with full skid, then flush with a same-cycle take, then an empty flush
    a_dn_ready = 1'b0;
    send_a(DATA_W'(16'h20));
    send_a(DATA_W'(16'h21));
    a_flush = 1'b1; a_up_valid = 1'b1; a_up_data = DATA_W'(16'h77);
    step();
    a_flush = 1'b0; a_up_valid = 1'b0;
    chk("flush_valid", 32'(a_dn_valid), 32'(0));
    chk("flush_data",  32'(a_dn_data),  32'(0));
    chk("flush_occ",   32'(a_occ),      32'(0));
    send_a(DATA_W'(16'h22));
    a_flush = 1'b1; a_up_valid = 1'b1; a_up_data = DATA_W'(16'h78);
    step();
    chk("flush_take_done", 32'(a_took), 32'(1));
    a_flush = 1'b0; a_up_valid = 1'b0; a_dn_ready = 1'b1;
    step();
    step();
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    chk("flush_cnt2", 32'(a_flush_cnt), 32'(PERF ? 2 : 0));

    // flush beats stall in the same cycle
    send_a(DATA_W'(16'h30));
    a_stall = 1'b1; a_flush = 1'b1;
    step();
    a_stall = 1'b0; a_flush = 1'b0;
    chk("flush_vs_stall_occ", 32'(a_occ), 32'(0));
    step();

    // reset in the middle of a transfer
    a_dn_ready = 1'b0;
    send_a(DATA_W'(16'h40));
    send_a(DATA_W'(16'h41));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(a_dn_valid), 32'(0));
    chk("rst_mid_occ",   32'(a_occ),      32'(0));
    a_dn_ready = 1'b1;
    step();

    // single-entry instance: ready follows downstream combinationally
    b_dn_ready = 1'b1; b_up_valid = 1'b1; b_up_data = DATA_W'(5);
    step();
    b_up_data = DATA_W'(6); b_dn_ready = 1'b0;
    step();
    b_dn_ready = 1'b1;
    step();
    chk("b_took_6", 32'(b_took), 32'(1));
    b_up_data = DATA_W'(7);
    step();
    b_up_valid = 1'b0;
    step();
    step();
    b_up_valid = 1'b1; b_up_data = DATA_W'(8);
    step();
    b_up_valid = 1'b0; b_stall = 1'b1;
    step();
    b_flush = 1'b1;
    step();
    b_flush = 1'b0; b_stall = 1'b0;
    chk("b_flush_occ", 32'(b_occ), 32'(0));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline-stage register, replacing per-stage hand-written boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus. Supports a valid/ready handshake with a 2-entry skid buffer so back-pressure never drops or duplicates a beat.
- Also honours the core's legacy per-stage stall and flush (jump) controls.
- Output bubbles are all-zero payload, so a killed slot decodes as a NOP downstream.

Parameters:
- DATA_W, 128, payload width in bits (pc, operands, imm, rd, rd_enable, aluop, alusel packed by the instantiator).
- SKID_EN, 1, 1 = two entries (main + skid, full throughput under registered ready); 0 = single entry, up_ready_o combinational.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- up_valid_i  in  1  upstream beat present
- up_ready_o  out  1  stage can accept a beat this cycle
- up_data_i  in  DATA_W  upstream payload
- dn_valid_o  out  1  output beat valid
- dn_ready_i  in  1  downstream accepts the beat
- dn_data_o  out  DATA_W  output payload; all-zero when dn_valid_o=0
- stall_i  in  1  legacy hold: treated as dn_ready_i=0 for this cycle
- flush_i  in  1  legacy flush/jump kill: empties the stage
- occ_o  out  2  entries held (0..2; max 1 when SKID_EN=0)
- stall_cnt_o  out  CNT_W  cycles with dn_valid_o=1 and not consumed (feature only)
- flush_cnt_o  out  CNT_W  flush events that killed at least one valid entry (feature only)

Behaviour:
- Definitions:
  - take = up_valid_i & up_ready_o.
  - give = dn_valid_o & dn_ready_i & ~stall_i.
- Priority each cycle: rst > flush_i > normal update.
- Reset: main_valid=0, skid_valid=0, main/skid payload=0. Resulting outputs:
  - dn_valid_o=0, dn_data_o=0, occ_o=0.
  - up_ready_o=1 (SKID_EN=1) or ~stall_i-independent 1 (SKID_EN=0, stage empty).
  - Counters=0.
- Reset mid-transfer discards all held beats; no beat is emitted in the reset cycle or the cycle after.
- Flush:
  - Both entries invalidated and payload zeroed on the next edge.
  - A beat taken in the same cycle is discarded; the handshake still completes and upstream considers it consumed.
  - dn_valid_o=0 on the cycle after flush.
- SKID_EN=1:
  - up_ready_o = ~skid_valid (registered, no combinational path from dn_ready_i).
  - Main empty or give: main <= skid if skid_valid, else the incoming beat if take; otherwise main empties.
  - When skid is drained into main and take also occurs, the incoming beat goes to skid.
  - Main full, no give, take: beat goes to skid; up_ready_o drops the next cycle.
  - Order strictly FIFO; latency 1 cycle from take to dn_valid_o when empty.
- SKID_EN=0:
  - up_ready_o = ~main_valid | give (combinational through dn_ready_i/stall_i).
  - Main loads on take.
- dn_data_o = main payload when main_valid, else 0.
- Payload registers load only on take (no toggling while holding).
- occ_o = main_valid + skid_valid; invariant: skid_valid implies main_valid.
- Simultaneous stall_i=1 and flush_i=1: flush wins.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments on each cycle with dn_valid_o & ~give.
  - flush_cnt_o increments on each flush_i cycle with occ_o>0 or take.
  - Both saturate at all-ones and clear on rst.
- Undefined: counter logic absent; stall_cnt_o and flush_cnt_o tied to 0.

Decomposition:
- Shared package pipe_pkg:
  - OCC_W=2.
  - Zero-bubble constant helper.
  - Counter saturating-increment function.
  - Localparams PIPE_OCC_EMPTY/ONE/FULL.
- One sub-module pipe_slot: DATA_W register with valid bit, load/clear controls, zero-on-clear; instantiated twice (main, skid; skid only when SKID_EN=1).

Test Plan:
- Reset then stream:
  - Stimulus: rst 2 cycles, then up_valid_i=1 with data 1,2,3,4 on consecutive cycles, dn_ready_i=1.
  - Response: dn_data_o 1,2,3,4 one cycle later each; up_ready_o=1 throughout; occ_o≤1.
- Back-pressure:
  - Stimulus: stream 10,11,12, dn_ready_i=0 from the cycle after 10 appears.
  - Response: 11 lands in skid; up_ready_o=0; 12 held upstream; release gives 10,11,12 in order with no loss or duplication.
- Legacy stall:
  - Stimulus: stall_i=1 for 3 cycles while dn_valid_o=1 with data 0x55.
  - Response: dn_data_o stays 0x55; with feature on, stall_cnt_o=3.
- Flush with full skid:
  - Stimulus: occ_o=2, flush_i=1 together with take of 0x77.
  - Response: next cycle dn_valid_o=0, dn_data_o=0, occ_o=0; 0x77 never appears; flush_cnt_o=1.
- Flush vs stall:
  - Stimulus: flush_i=1 and stall_i=1 in the same cycle.
  - Response: stage empties.
- SKID_EN=0:
  - Stimulus: dn_ready_i toggling 1,0,1 with continuous upstream data 5,6,7.
  - Response: up_ready_o follows ~main_valid | give combinationally; output order 5,6,7.
